// File: rtl/dmem_arbiter.sv
// Two-port (CPU, DMA) sequencer for a single-port sync data RAM: size/byte-lane handling, round-robin on ties.
// Latency: write/misaligned ready at cycle 2, read at 2+RAM_LAT; backpressure: req held until one-cycle ready pulse.
module dmem_arbiter #(
   parameter int AW      = 12,
   parameter int RAM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic [31:0]   cpu_addr,
   input  logic          cpu_we,
   input  logic [1:0]    cpu_size,
   input  logic [31:0]   cpu_wdata,
   output logic [31:0]   cpu_rdata,
   output logic          cpu_ready,
   output logic          cpu_err,
   input  logic          dma_req,
   input  logic [31:0]   dma_addr,
   input  logic          dma_we,
   input  logic [1:0]    dma_size,
   input  logic [31:0]   dma_wdata,
   output logic [31:0]   dma_rdata,
   output logic          dma_ready,
   output logic          dma_err,
   output logic          ram_en,
   output logic [3:0]    ram_be,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_wdata,
   input  logic [31:0]   ram_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   localparam logic [1:0] LAST_CNT = 2'(RAM_LAT - 1);

   state_t        state, state_nxt;
   logic          last_dma, last_dma_nxt;
   logic          gnt_dma, gnt_dma_nxt;
   logic          l_we, l_we_nxt;
   logic [1:0]    l_size, l_size_nxt;
   logic [1:0]    l_off, l_off_nxt;
   logic          l_mis, l_mis_nxt;
   logic [1:0]    cnt, cnt_nxt;

   logic [31:0]   cpu_rdata_nxt, dma_rdata_nxt;
   logic          cpu_ready_nxt, dma_ready_nxt, cpu_err_nxt, dma_err_nxt;
   logic          ram_en_nxt;
   logic [3:0]    ram_be_nxt;
   logic [AW-1:0] ram_addr_nxt;
   logic [31:0]   ram_wdata_nxt;

   logic          pick_dma, s_we, s_mis;
   logic [31:0]   s_addr, s_wdata, s_rep, rd_shift, rd_fmt;
   logic [1:0]    s_size;
   logic [3:0]    s_be;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^s_addr[31:AW+2];

   // Request mux and lane formatting; a tie goes to the port that did not win last time.
   always_comb begin
      pick_dma = dma_req & (~cpu_req | ~last_dma);
      s_addr   = pick_dma ? dma_addr  : cpu_addr;
      s_we     = pick_dma ? dma_we    : cpu_we;
      s_size   = pick_dma ? dma_size  : cpu_size;
      s_wdata  = pick_dma ? dma_wdata : cpu_wdata;
      s_mis    = ((s_size == 2'd1) & s_addr[0]) | (s_size[1] & (s_addr[1:0] != 2'b00));
      case (s_size)
         2'd0: begin
            s_be  = 4'b0001 << s_addr[1:0];
            s_rep = {4{s_wdata[7:0]}};
         end
         2'd1: begin
            s_be  = 4'b0011 << s_addr[1:0];
            s_rep = {2{s_wdata[15:0]}};
         end
         default: begin
            s_be  = 4'b1111;
            s_rep = s_wdata;
         end
      endcase
      rd_shift = ram_rdata >> {l_off, 3'b000};
      case (l_size)
         2'd0:    rd_fmt = {24'd0, rd_shift[7:0]};
         2'd1:    rd_fmt = {16'd0, rd_shift[15:0]};
         default: rd_fmt = rd_shift;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      last_dma_nxt  = last_dma;
      gnt_dma_nxt   = gnt_dma;
      l_we_nxt      = l_we;
      l_size_nxt    = l_size;
      l_off_nxt     = l_off;
      l_mis_nxt     = l_mis;
      cnt_nxt       = cnt;
      cpu_rdata_nxt = cpu_rdata;
      dma_rdata_nxt = dma_rdata;
      cpu_ready_nxt = 1'b0;
      dma_ready_nxt = 1'b0;
      cpu_err_nxt   = 1'b0;
      dma_err_nxt   = 1'b0;
      ram_en_nxt    = 1'b0;
      ram_be_nxt    = 4'b0000;
      ram_addr_nxt  = '0;
      ram_wdata_nxt = '0;
      case (state)
         IDLE: begin
            if (cpu_req | dma_req) begin
               state_nxt    = ISSUE;
               last_dma_nxt = pick_dma;
               gnt_dma_nxt  = pick_dma;
               l_we_nxt     = s_we;
               l_size_nxt   = s_size;
               l_off_nxt    = s_addr[1:0];
               l_mis_nxt    = s_mis;
               // Strobe registered here so it appears during ISSUE; misaligned never touches the RAM.
               if (!s_mis) begin
                  ram_en_nxt    = 1'b1;
                  ram_addr_nxt  = s_addr[AW+1:2];
                  ram_be_nxt    = s_we ? s_be  : 4'b0000;
                  ram_wdata_nxt = s_we ? s_rep : 32'd0;
               end
            end
         end
         ISSUE: begin
            if (l_we | l_mis) begin
               state_nxt = DONE;
               if (gnt_dma) begin
                  dma_ready_nxt = 1'b1;
                  dma_err_nxt   = l_mis;
                  if (l_mis) dma_rdata_nxt = 32'd0;
               end else begin
                  cpu_ready_nxt = 1'b1;
                  cpu_err_nxt   = l_mis;
                  if (l_mis) cpu_rdata_nxt = 32'd0;
               end
            end else begin
               state_nxt = WAIT;
               cnt_nxt   = 2'd0;
            end
         end
         WAIT: begin
            if (cnt == LAST_CNT) begin
               state_nxt = DONE;
               if (gnt_dma) begin
                  dma_ready_nxt = 1'b1;
                  dma_rdata_nxt = rd_fmt;
               end else begin
                  cpu_ready_nxt = 1'b1;
                  cpu_rdata_nxt = rd_fmt;
               end
            end else begin
               cnt_nxt = cnt + 2'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         last_dma  <= 1'b1;
         gnt_dma   <= 1'b0;
         l_we      <= 1'b0;
         l_size    <= 2'd0;
         l_off     <= 2'd0;
         l_mis     <= 1'b0;
         cnt       <= 2'd0;
         cpu_rdata <= 32'd0;
         dma_rdata <= 32'd0;
         cpu_ready <= 1'b0;
         dma_ready <= 1'b0;
         cpu_err   <= 1'b0;
         dma_err   <= 1'b0;
         ram_en    <= 1'b0;
         ram_be    <= 4'b0000;
         ram_addr  <= '0;
         ram_wdata <= 32'd0;
      end else begin
         state     <= state_nxt;
         last_dma  <= last_dma_nxt;
         gnt_dma   <= gnt_dma_nxt;
         l_we      <= l_we_nxt;
         l_size    <= l_size_nxt;
         l_off     <= l_off_nxt;
         l_mis     <= l_mis_nxt;
         cnt       <= cnt_nxt;
         cpu_rdata <= cpu_rdata_nxt;
         dma_rdata <= dma_rdata_nxt;
         cpu_ready <= cpu_ready_nxt;
         dma_ready <= dma_ready_nxt;
         cpu_err   <= cpu_err_nxt;
         dma_err   <= dma_err_nxt;
         ram_en    <= ram_en_nxt;
         ram_be    <= ram_be_nxt;
         ram_addr  <= ram_addr_nxt;
         ram_wdata <= ram_wdata_nxt;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model checked every cycle, plus directed literal checks.
module tb_dmem_arbiter;
   localparam int AW = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Main DUT (RAM_LAT = 1)
   logic cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [1:0]  cpu_size, dma_size;
   logic [31:0] cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
   logic        cpu_ready, cpu_err, dma_ready, dma_err, ram_en;
   logic [3:0]  ram_be;
   logic [AW-1:0] ram_addr;

   // Second DUT (RAM_LAT = 3)
   logic t3_cpu_req, t3_cpu_we, t3_dma_req, t3_dma_we;
   logic [31:0] t3_cpu_addr, t3_cpu_wdata, t3_dma_addr, t3_dma_wdata;
   logic [1:0]  t3_cpu_size, t3_dma_size;
   logic [31:0] t3_cpu_rdata, t3_dma_rdata, t3_ram_wdata, t3_ram_rdata;
   logic        t3_cpu_ready, t3_cpu_err, t3_dma_ready, t3_dma_err, t3_ram_en;
   logic [3:0]  t3_ram_be;
   logic [AW-1:0] t3_ram_addr;

   dmem_arbiter #(.AW(AW), .RAM_LAT(1)) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_size(cpu_size),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_size(dma_size),
      .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ready(dma_ready), .dma_err(dma_err),
      .ram_en(ram_en), .ram_be(ram_be), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   dmem_arbiter #(.AW(AW), .RAM_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .cpu_req(t3_cpu_req), .cpu_addr(t3_cpu_addr), .cpu_we(t3_cpu_we), .cpu_size(t3_cpu_size),
      .cpu_wdata(t3_cpu_wdata), .cpu_rdata(t3_cpu_rdata), .cpu_ready(t3_cpu_ready), .cpu_err(t3_cpu_err),
      .dma_req(t3_dma_req), .dma_addr(t3_dma_addr), .dma_we(t3_dma_we), .dma_size(t3_dma_size),
      .dma_wdata(t3_dma_wdata), .dma_rdata(t3_dma_rdata), .dma_ready(t3_dma_ready), .dma_err(t3_dma_err),
      .ram_en(t3_ram_en), .ram_be(t3_ram_be), .ram_addr(t3_ram_addr), .ram_wdata(t3_ram_wdata),
      .ram_rdata(t3_ram_rdata)
   );

   // RAM models: poison data when not strobed so latency errors show up.
   logic [31:0] mem1 [0:4095];
   logic [31:0] mem3 [0:4095];
   logic [31:0] rd1;
   logic [31:0] pipe3 [0:2];
   assign ram_rdata    = rd1;
   assign t3_ram_rdata = pipe3[2];

   always @(posedge clk) begin
      rd1 <= ram_en ? mem1[ram_addr] : 32'hBAD1BAD1;
      if (ram_en)
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) mem1[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
   end

   always @(posedge clk) begin
      pipe3[0] <= t3_ram_en ? mem3[t3_ram_addr] : 32'hBAD3BAD3;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
      if (t3_ram_en)
         for (int b = 0; b < 4; b++)
            if (t3_ram_be[b]) mem3[t3_ram_addr][8*b +: 8] = t3_ram_wdata[8*b +: 8];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model of u_dut: one transaction at a time, byte-addressed memory.
   logic [7:0]  ref_mem [0:16383];
   int          cyc = 0;
   int          free_cyc = 0, issue_cyc = -1, done_cyc = -1;
   bit          last_dma = 1'b1;
   bit          m_dma, m_mis, m_we, m_en, m_chk_rd;
   logic [3:0]  m_be;
   logic [AW-1:0] m_addr;
   logic [31:0] m_wdata, m_rdata;

   task automatic model_reset();
      free_cyc  = 0;
      issue_cyc = -1;
      done_cyc  = -1;
      last_dma  = 1'b1;
   endtask

   always @(posedge rst) model_reset();

   always @(posedge clk) begin
      logic [31:0] a, wd;
      logic [1:0]  sz;
      int          nb, base;
      cyc++;
      if (rst) begin
         model_reset();
      end else if ((cyc - 1) >= free_cyc && (cpu_req || dma_req)) begin
         m_dma    = dma_req && (!cpu_req || !last_dma);
         last_dma = m_dma;
         a        = m_dma ? dma_addr  : cpu_addr;
         wd       = m_dma ? dma_wdata : cpu_wdata;
         sz       = m_dma ? dma_size  : cpu_size;
         m_we     = m_dma ? dma_we    : cpu_we;
         nb       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
         m_mis    = (a % nb) != 0;
         m_en     = !m_mis;
         m_addr   = a[AW+1:2];
         base     = int'(a[AW+1:0]);
         m_be     = 4'b0000;
         m_wdata  = 32'd0;
         m_rdata  = 32'd0;
         if (!m_mis && m_we) begin
            for (int i = 0; i < nb; i++) begin
               m_be[(base + i) % 4] = 1'b1;
               ref_mem[base + i] = wd[8*i +: 8];
            end
            for (int k = 0; k < 4; k++) m_wdata[8*k +: 8] = wd[8*(k % nb) +: 8];
         end
         if (!m_mis && !m_we)
            for (int i = 0; i < nb; i++) m_rdata[8*i +: 8] = ref_mem[base + i];
         m_chk_rd  = m_mis || !m_we;
         issue_cyc = cyc;
         done_cyc  = (m_mis || m_we) ? cyc + 1 : cyc + 2;
         free_cyc  = done_cyc + 1;
      end
   end

   always @(negedge clk) begin
      bit e_cpu, e_dma;
      if (rst) begin
         chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
         chk("rst_dma_ready", {31'd0, dma_ready}, 32'd0);
         chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
      end else begin
         e_cpu = (cyc == done_cyc) && !m_dma;
         e_dma = (cyc == done_cyc) && m_dma;
         chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, e_cpu});
         chk("dma_ready", {31'd0, dma_ready}, {31'd0, e_dma});
         chk("ram_en", {31'd0, ram_en}, {31'd0, (cyc == issue_cyc) && m_en});
         if (cyc == issue_cyc) begin
            chk("ram_be", {28'd0, ram_be}, {28'd0, m_be});
            if (m_en) chk("ram_addr", {20'd0, ram_addr}, {20'd0, m_addr});
            if (m_en && m_we) chk("ram_wdata", ram_wdata, m_wdata);
         end
         if (e_cpu) begin
            chk("cpu_err", {31'd0, cpu_err}, {31'd0, m_mis});
            if (m_chk_rd) chk("cpu_rdata", cpu_rdata, m_rdata);
         end
         if (e_dma) begin
            chk("dma_err", {31'd0, dma_err}, {31'd0, m_mis});
            if (m_chk_rd) chk("dma_rdata", dma_rdata, m_rdata);
         end
      end
   end

   // RAM strobe monitor for literal checks.
   int          en_cnt = 0;
   logic [AW-1:0] last_ram_addr;
   logic [3:0]  last_ram_be;
   logic [31:0] last_ram_wdata;
   always @(negedge clk) begin
      if (ram_en) begin
         en_cnt++;
         last_ram_addr  = ram_addr;
         last_ram_be    = ram_be;
         last_ram_wdata = ram_wdata;
      end
   end

   task automatic txn(input bit dma, input bit we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output bit err, output int lat);
      @(negedge clk);
      if (dma) begin
         dma_req = 1; dma_we = we; dma_size = sz; dma_addr = a; dma_wdata = wd;
      end else begin
         cpu_req = 1; cpu_we = we; cpu_size = sz; cpu_addr = a; cpu_wdata = wd;
      end
      lat = 0; rd = 32'd0; err = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (dma ? dma_ready : cpu_ready) begin
            lat = n;
            rd  = dma ? dma_rdata : cpu_rdata;
            err = dma ? dma_err : cpu_err;
            break;
         end
      end
      if (dma) dma_req = 0; else cpu_req = 0;
      if (lat == 0) chk("txn_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      repeat (2) @(negedge clk);
      #2 rst = 0;
   endtask

   initial begin
      logic [31:0] rd;
      bit          err;
      int          lat, en0, got;
      bit          q_order [$];

      cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_size = 0; dma_addr = 0; dma_wdata = 0;
      t3_cpu_req = 0; t3_cpu_we = 0; t3_cpu_size = 0; t3_cpu_addr = 0; t3_cpu_wdata = 0;
      t3_dma_req = 0; t3_dma_we = 0; t3_dma_size = 0; t3_dma_addr = 0; t3_dma_wdata = 0;
      for (int i = 0; i < 4096; i++) begin
         mem1[i] = 32'd0;
         mem3[i] = 32'd0;
      end
      for (int i = 0; i < 16384; i++) ref_mem[i] = 8'd0;

      #1;
      chk("reset_cpu_ready", {31'd0, cpu_ready}, 32'd0);
      chk("reset_cpu_rdata", cpu_rdata, 32'd0);
      chk("reset_ram_be", {28'd0, ram_be}, 32'd0);
      repeat (2) @(negedge clk);
      #2 rst = 0;

      // 1: word store then load
      txn(0, 1, 2'd2, 32'h10, 32'hDEADBEEF, rd, err, lat);
      chk("t1_store_lat", 32'(lat), 32'd2);
      chk("t1_store_addr", {20'd0, last_ram_addr}, 32'd4);
      chk("t1_store_be", {28'd0, last_ram_be}, 32'hF);
      txn(0, 0, 2'd2, 32'h10, 32'd0, rd, err, lat);
      chk("t1_load_lat", 32'(lat), 32'd3);
      chk("t1_load_data", rd, 32'hDEADBEEF);

      // 2: byte lane handling
      txn(0, 1, 2'd0, 32'h13, 32'h000000A5, rd, err, lat);
      chk("t2_store_be", {28'd0, last_ram_be}, 32'h8);
      chk("t2_store_wdata", last_ram_wdata, 32'hA5A5A5A5);
      txn(0, 0, 2'd0, 32'h13, 32'd0, rd, err, lat);
      chk("t2_load_byte", rd, 32'h000000A5);
      txn(0, 0, 2'd1, 32'h12, 32'd0, rd, err, lat);
      chk("t2_load_half", rd, 32'h0000A5AD);

      // 3: misaligned accesses
      txn(0, 1, 2'd2, 32'h0, 32'h11223344, rd, err, lat);
      en0 = en_cnt;
      txn(0, 0, 2'd2, 32'h06, 32'd0, rd, err, lat);
      chk("t3_mis_load_err", {31'd0, err}, 32'd1);
      chk("t3_mis_load_data", rd, 32'd0);
      chk("t3_mis_load_lat", 32'(lat), 32'd2);
      txn(0, 1, 2'd1, 32'h01, 32'h0000FFFF, rd, err, lat);
      chk("t3_mis_store_err", {31'd0, err}, 32'd1);
      chk("t3_mis_no_ram_en", 32'(en_cnt - en0), 32'd0);
      txn(0, 0, 2'd2, 32'h0, 32'd0, rd, err, lat);
      chk("t3_word_unchanged", rd, 32'h11223344);
      chk("t3_aligned_err", {31'd0, err}, 32'd0);

      // 4: both ports requesting continuously from reset
      do_reset();
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_size = 2'd2; cpu_addr = 32'h100; cpu_wdata = 32'hC0000000;
      dma_req = 1; dma_we = 1; dma_size = 2'd2; dma_addr = 32'h200; dma_wdata = 32'hD0000000;
      for (int n = 0; n < 60 && q_order.size() < 6; n++) begin
         @(negedge clk);
         if (cpu_ready) begin
            q_order.push_back(1'b0);
            cpu_addr += 4; cpu_wdata += 1;
         end
         if (dma_ready) begin
            q_order.push_back(1'b1);
            dma_addr += 4; dma_wdata += 1;
         end
      end
      cpu_req = 0; dma_req = 0;
      chk("t4_count", 32'(q_order.size()), 32'd6);
      for (int i = 0; i < 6 && i < q_order.size(); i++)
         chk($sformatf("t4_grant%0d", i), {31'd0, q_order[i]}, 32'(i % 2));
      txn(1, 0, 2'd2, 32'h204, 32'd0, rd, err, lat);
      chk("t4_dma_readback", rd, 32'hD0000001);

      // 5: RAM_LAT = 3 DMA read, address wiggled during WAIT
      @(negedge clk);
      t3_dma_req = 1; t3_dma_we = 1; t3_dma_size = 2'd2; t3_dma_addr = 32'h40; t3_dma_wdata = 32'hCAFEF00D;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (t3_dma_ready) begin lat = n; break; end
      end
      t3_dma_req = 0;
      chk("t5_store_lat", 32'(lat), 32'd2);
      @(negedge clk);
      t3_dma_req = 1; t3_dma_we = 0; t3_dma_addr = 32'h40;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 2 || n == 3) t3_dma_addr = 32'h80 + 32'(n);
         if (t3_dma_ready) begin
            lat = n;
            rd  = t3_dma_rdata;
            break;
         end
      end
      t3_dma_req = 0;
      chk("t5_load_lat", 32'(lat), 32'd5);
      chk("t5_load_data", rd, 32'hCAFEF00D);

      // 6: reset during WAIT of a CPU read
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_size = 2'd2; cpu_addr = 32'h10;
      repeat (2) @(negedge clk);
      dma_req = 1; dma_we = 0; dma_size = 2'd2; dma_addr = 32'h0;
      #2 rst = 1;
      #1;
      chk("t6_async_cpu_ready", {31'd0, cpu_ready}, 32'd0);
      chk("t6_async_cpu_rdata", cpu_rdata, 32'd0);
      chk("t6_async_dma_rdata", dma_rdata, 32'd0);
      chk("t6_async_ram", {ram_en, ram_be, 15'd0, ram_addr}, 32'd0);
      chk("t6_async_ram_wdata", ram_wdata, 32'd0);
      repeat (3) @(negedge clk);
      #2 rst = 0;
      got = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (cpu_ready || dma_ready) begin
            got = n;
            chk("t6_first_is_cpu", {30'd0, cpu_ready, dma_ready}, 32'b10);
            chk("t6_cpu_data", cpu_rdata, 32'hA5ADBEEF);
            cpu_req = 0;
            break;
         end
      end
      if (got == 0) chk("t6_timeout", 32'd0, 32'd1);
      got = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (dma_ready) begin
            got = n;
            chk("t6_dma_data", dma_rdata, 32'h11223344);
            break;
         end
      end
      dma_req = 0;
      if (got == 0) chk("t6_dma_timeout", 32'd0, 32'd1);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
